// File: rtl/dcache_direct_pkg.sv
// dcache_direct_pkg
//   Shared types and helpers for the direct-mapped data cache.
//   - state_e    : cache controller states (idle / line fill / fill response)
//   - lane_get   : extract a big-endian byte lane from a 32-bit word
//   - lane_put   : replace a big-endian byte lane inside a 32-bit word
//   - load_fmt   : shape array data into load data (word, or zero-extended byte)
package dcache_direct_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Big-endian lanes: byte offset 0 is the most significant byte.
  function automatic logic [7:0] lane_get(input logic [WORD_W-1:0] word,
                                          input logic [1:0]        lane);
    case (lane)
      2'd0:    return word[31:24];
      2'd1:    return word[23:16];
      2'd2:    return word[15:8];
      default: return word[7:0];
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] lane_put(input logic [WORD_W-1:0] word,
                                                 input logic [1:0]        lane,
                                                 input logic [7:0]        b);
    logic [WORD_W-1:0] w;
    w = word;
    case (lane)
      2'd0:    w[31:24] = b;
      2'd1:    w[23:16] = b;
      2'd2:    w[15:8]  = b;
      default: w[7:0]   = b;
    endcase
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] load_fmt(input logic [WORD_W-1:0] word,
                                                 input logic              is_byte,
                                                 input logic [1:0]        lane);
    return is_byte ? {24'h0, lane_get(word, lane)} : word;
  endfunction

endpackage

// File: rtl/dcache_tag_array.sv
// dcache_tag_array
//   SETS x {valid, tag} storage for the direct-mapped cache.
//   Ports:
//     clk, reset        clock, synchronous active-low reset (clears all valid bits)
//     rd_idx_i          lookup index; rd_valid_o / rd_tag_o are combinational
//     clr_i, clr_idx_i  invalidate one line at the next edge
//     set_i, set_idx_i, set_tag_i   write a tag and mark the line valid
module dcache_tag_array #(
  parameter  int unsigned SETS  = 16,
  parameter  int unsigned TAG_W = 24,
  localparam int unsigned IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] clr_idx_i,
  input  logic             set_i,
  input  logic [IDX_W-1:0] set_idx_i,
  input  logic [TAG_W-1:0] set_tag_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q[clr_idx_i] <= 1'b0;
      if (set_i) valid_q[set_idx_i] <= 1'b1;
    end
  end

  // NOTE: tag storage has no reset; a tag is only meaningful behind its valid
  // bit, so clearing the valid bits is enough and keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (set_i) tag_q[set_idx_i] <= set_tag_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/dcache_direct.sv
// dcache_direct
//   Direct-mapped, write-through, no-write-allocate data cache between the
//   MEM stage and a synchronous memory (read data one cycle after address).
//   CPU side : req_valid, req_write, req_byte, req_addr, req_wdata -> rdata, ready
//   Memory   : mem_addr, mem_data_in, mem_write_enable, mem_byte_enable,
//              mem_master_enable -> mem_data_out
//   Load hits complete combinationally; load misses fill the whole line
//   with word reads and answer from the RESP state. Stores always write
//   through in one cycle and update the line only on a hit.
module dcache_direct
  import dcache_direct_pkg::*;
#(
  parameter int unsigned SETS       = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data_in,
  input  logic [31:0]       mem_data_out,
  output logic              mem_write_enable,
  output logic              mem_byte_enable,
  output logic              mem_master_enable
);

  localparam int unsigned WORD_BITS = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W     = $clog2(SETS);
  localparam int unsigned OFF_W     = WORD_BITS + 2;
  localparam int unsigned TAG_W     = ADDR_W - OFF_W - IDX_W;
  localparam int unsigned PTR_W     = IDX_W + WORD_BITS;
  localparam int unsigned CNT_W     = WORD_BITS + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_WORDS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   miss_addr_q, miss_addr_d;
  logic                miss_byte_q, miss_byte_d;
  logic [31:0]         data_q [SETS*LINE_WORDS];

  // Address fields of the live request and of the latched miss.
  logic [IDX_W-1:0]     req_idx, miss_idx;
  logic [WORD_BITS-1:0] req_word, miss_word, fill_word;
  logic [TAG_W-1:0]     req_tag, miss_tag;
  logic [PTR_W-1:0]     req_ptr, miss_ptr, fill_ptr;

  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign req_word  = req_addr[2 +: WORD_BITS];
  assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
  assign miss_idx  = miss_addr_q[OFF_W +: IDX_W];
  assign miss_word = miss_addr_q[2 +: WORD_BITS];
  assign miss_tag  = miss_addr_q[ADDR_W-1 -: TAG_W];
  assign req_ptr   = {req_idx, req_word};
  assign miss_ptr  = {miss_idx, miss_word};

  // Word captured this cycle is the one requested in the previous cycle.
  logic [CNT_W-1:0] cnt_prev;
  assign cnt_prev  = cnt_q - CNT_W'(1);
  assign fill_word = cnt_prev[WORD_BITS-1:0];
  assign fill_ptr  = {miss_idx, fill_word};

  // Tag lookup
  logic             tag_valid;
  logic [TAG_W-1:0] tag_rd;
  logic             hit;
  logic             in_idle_req;
  logic             load_miss;
  logic             fill_done;

  assign hit         = tag_valid && (tag_rd == req_tag);
  assign in_idle_req = reset && (state_q == ST_IDLE) && req_valid;
  assign load_miss   = in_idle_req && !req_write && !hit;
  assign fill_done   = (state_q == ST_FILL) && (cnt_q == CNT_LAST);

  dcache_tag_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_tags (
    .clk        (clk),
    .reset      (reset),
    .rd_idx_i   (req_idx),
    .rd_valid_o (tag_valid),
    .rd_tag_o   (tag_rd),
    .clr_i      (load_miss),
    .clr_idx_i  (req_idx),
    .set_i      (fill_done),
    .set_idx_i  (miss_idx),
    .set_tag_i  (miss_tag)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      miss_addr_q <= '0;
      miss_byte_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_addr_q <= miss_addr_d;
      miss_byte_q <= miss_byte_d;
    end
  end

  // Next-state logic
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_addr_d = miss_addr_q;
    miss_byte_d = miss_byte_q;
    case (state_q)
      ST_IDLE: begin
        if (load_miss) begin
          state_d     = ST_FILL;
          cnt_d       = '0;
          miss_addr_d = req_addr;
          miss_byte_d = req_byte;
        end
      end
      ST_FILL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic; everything is held quiet while reset is asserted so no
  // memory write can leak out during a reset cycle.
  always_comb begin
    ready             = 1'b0;
    rdata             = '0;
    mem_addr          = '0;
    mem_data_in       = '0;
    mem_write_enable  = 1'b0;
    mem_byte_enable   = 1'b0;
    mem_master_enable = 1'b0;
    if (reset) begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_write) begin
            ready             = 1'b1;
            mem_master_enable = 1'b1;
            mem_write_enable  = 1'b1;
            mem_byte_enable   = req_byte;
            mem_addr          = req_addr;
            mem_data_in       = req_wdata;
          end else if (req_valid && hit) begin
            ready = 1'b1;
            rdata = load_fmt(data_q[req_ptr], req_byte, req_addr[1:0]);
          end
        end
        ST_FILL: begin
          if (cnt_q < CNT_LAST) begin
            mem_master_enable = 1'b1;
            mem_addr = {miss_addr_q[ADDR_W-1:OFF_W], cnt_q[WORD_BITS-1:0], 2'b00};
          end
        end
        ST_RESP: begin
          ready = 1'b1;
          rdata = load_fmt(data_q[miss_ptr], miss_byte_q, miss_addr_q[1:0]);
        end
        default: ;
      endcase
    end
  end

  // Data array: fill capture and store-hit update never overlap because
  // stores are only accepted in IDLE.
  logic        fill_we, store_we;
  logic [31:0] store_word;

  assign fill_we    = reset && (state_q == ST_FILL) && (cnt_q != '0);
  assign store_we   = in_idle_req && req_write && hit;
  assign store_word = req_byte ? lane_put(data_q[req_ptr], req_addr[1:0], req_wdata[7:0])
                               : req_wdata;

  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[fill_ptr] <= mem_data_out;
    end else if (store_we) begin
      data_q[req_ptr] <= store_word;
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// tb_dcache_direct
//   Directed bench for dcache_direct. A behavioural synchronous memory
//   (read data one cycle after address) holds {4{A[7:0]}} at word address A
//   unless overwritten by a store from the cache.
module tb_dcache_direct;

  localparam int unsigned SETS       = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned ADDR_W     = 32;
  localparam int          MISS_LAT   = LINE_WORDS + 2;
  localparam int          MAX_WAIT   = 20;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_write;
  logic              req_byte;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [31:0]       rdata;
  logic              ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data_in;
  logic [31:0]       mem_data_out;
  logic              mem_write_enable;
  logic              mem_byte_enable;
  logic              mem_master_enable;

  int n_checks = 0;
  int n_fail   = 0;

  dcache_direct #(
    .SETS       (SETS),
    .LINE_WORDS (LINE_WORDS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_byte          (req_byte),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rdata             (rdata),
    .ready             (ready),
    .mem_addr          (mem_addr),
    .mem_data_in       (mem_data_in),
    .mem_data_out      (mem_data_out),
    .mem_write_enable  (mem_write_enable),
    .mem_byte_enable   (mem_byte_enable),
    .mem_master_enable (mem_master_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory
  logic [31:0] mem_wr [logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (mem_wr.exists(wa)) return mem_wr[wa];
    return {4{wa[7:0]}};
  endfunction

  initial mem_data_out = '0;

  always @(posedge clk) begin
    if (mem_master_enable) begin
      if (mem_write_enable) begin
        logic [31:0] wa, cur;
        int          sh;
        wa  = {mem_addr[31:2], 2'b00};
        cur = mem_word(wa);
        if (mem_byte_enable) begin
          sh = (3 - int'(mem_addr[1:0])) * 8;
          mem_wr[wa] = (cur & ~(32'hFF << sh)) | ({24'h0, mem_data_in[7:0]} << sh);
        end else begin
          mem_wr[wa] = mem_data_in;
        end
      end else begin
        mem_data_out <= mem_word(mem_addr);
      end
    end
  end

  // Per-load observations
  logic [31:0] mem_seq [$];
  logic        wr_seen;

  task automatic idle();
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_byte  = 1'b0;
  endtask

  // Issue a load and hold it until ready; lat counts cycles after the
  // request cycle (0 = same-cycle hit). lat==MAX_WAIT means no answer.
  task automatic do_load(input logic [31:0] addr, input logic is_byte,
                         output logic [31:0] data, output int lat);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_byte  = is_byte;
    req_addr  = addr;
    req_wdata = '0;
    #1;
    lat = 0;
    mem_seq.delete();
    wr_seen = 1'b0;
    while (ready !== 1'b1 && lat < MAX_WAIT) begin
      if (mem_master_enable) begin
        mem_seq.push_back(mem_addr);
        if (mem_write_enable) wr_seen = 1'b1;
      end
      @(posedge clk); #2;
      lat++;
    end
    if (mem_master_enable) mem_seq.push_back(mem_addr);
    data = rdata;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic is_byte,
                          input logic [31:0] wdata);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_byte  = is_byte;
    req_addr  = addr;
    req_wdata = wdata;
    #1;
    n_checks++;
    if ({ready, mem_master_enable, mem_write_enable, mem_byte_enable} !== {3'b111, is_byte}) begin
      n_fail++;
      $display("FAIL store_ctrl @%h: {ready,mme,mwe,mbe}=%b expected %b", addr,
               {ready, mem_master_enable, mem_write_enable, mem_byte_enable}, {3'b111, is_byte});
    end
    n_checks++;
    if (mem_addr !== addr) begin
      n_fail++;
      $display("FAIL store_addr: got %h expected %h", mem_addr, addr);
    end
    n_checks++;
    if (mem_data_in !== wdata) begin
      n_fail++;
      $display("FAIL store_data: got %h expected %h", mem_data_in, wdata);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({ready, mem_master_enable, mem_write_enable, mem_byte_enable} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000",
               {ready, mem_master_enable, mem_write_enable, mem_byte_enable});
    end
    n_checks++;
    if ({rdata, mem_addr, mem_data_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_data_in=%h expected all 0",
               rdata, mem_addr, mem_data_in);
    end
  endtask

  task automatic test_cold_load();
    logic [31:0] d;
    int          lat;
    logic [31:0] exp_seq [4];
    logic [31:0] act;
    exp_seq = '{32'h10, 32'h14, 32'h18, 32'h1C};
    do_load(32'h10, 1'b0, d, lat);
    n_checks++;
    if (lat !== MISS_LAT) begin
      n_fail++;
      $display("FAIL cold_latency: got %0d expected %0d", lat, MISS_LAT);
    end
    n_checks++;
    if (d !== 32'h10101010) begin
      n_fail++;
      $display("FAIL cold_rdata: got %h expected 10101010", d);
    end
    n_checks++;
    if (mem_seq.size() !== 4) begin
      n_fail++;
      $display("FAIL cold_nreads: got %0d expected 4", mem_seq.size());
    end
    for (int i = 0; i < 4; i++) begin
      act = (i < mem_seq.size()) ? mem_seq[i] : 32'hxxxxxxxx;
      n_checks++;
      if (act !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL cold_fill_addr[%0d]: got %h expected %h", i, act, exp_seq[i]);
      end
    end
    n_checks++;
    if (wr_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL cold_no_write: write strobe seen during fill");
    end
  endtask

  task automatic test_hit();
    logic [31:0] d;
    int          lat;
    do_load(32'h14, 1'b0, d, lat);
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL hit_latency: got %0d expected 0", lat);
    end
    n_checks++;
    if (d !== 32'h14141414) begin
      n_fail++;
      $display("FAIL hit_rdata: got %h expected 14141414", d);
    end
    n_checks++;
    if (mem_seq.size() !== 0) begin
      n_fail++;
      $display("FAIL hit_mem_idle: %0d memory accesses, expected 0", mem_seq.size());
    end
    do_load(32'h17, 1'b1, d, lat);
    n_checks++;
    if ({lat == 0, d} !== {1'b1, 32'h00000014}) begin
      n_fail++;
      $display("FAIL hit_byte_load: lat=%0d rdata=%h expected lat 0 rdata 00000014", lat, d);
    end
  endtask

  task automatic test_byte_store();
    logic [31:0] d;
    int          lat;
    do_store(32'h15, 1'b1, 32'h123456AB);
    do_load(32'h14, 1'b0, d, lat);
    n_checks++;
    if ({lat == 0, d} !== {1'b1, 32'h14AB1414}) begin
      n_fail++;
      $display("FAIL bstore_cache: lat=%0d rdata=%h expected lat 0 rdata 14AB1414", lat, d);
    end
    do_load(32'h15, 1'b1, d, lat);
    n_checks++;
    if (d !== 32'h000000AB) begin
      n_fail++;
      $display("FAIL bstore_lane1: got %h expected 000000AB", d);
    end
    do_load(32'h14, 1'b1, d, lat);
    n_checks++;
    if (d !== 32'h00000014) begin
      n_fail++;
      $display("FAIL bstore_lane0: got %h expected 00000014", d);
    end
    n_checks++;
    if (mem_word(32'h14) !== 32'h14AB1414) begin
      n_fail++;
      $display("FAIL bstore_memory: got %h expected 14AB1414", mem_word(32'h14));
    end
  endtask

  task automatic test_store_miss();
    logic [31:0] d;
    int          lat;
    do_store(32'h40, 1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      idle();
      #1;
      n_checks++;
      if ({ready, mem_master_enable} !== 2'b00) begin
        n_fail++;
        $display("FAIL smiss_no_fill[%0d]: {ready,mme}=%b expected 00", i, {ready, mem_master_enable});
      end
    end
    do_load(32'h40, 1'b0, d, lat);
    n_checks++;
    if (lat !== MISS_LAT) begin
      n_fail++;
      $display("FAIL smiss_load_latency: got %0d expected %0d", lat, MISS_LAT);
    end
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL smiss_load_rdata: got %h expected DEADBEEF", d);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    int          lat;
    logic [31:0] alias_addr;
    alias_addr = 32'h10 + 16 * SETS * LINE_WORDS;
    do_load(32'h10, 1'b0, d, lat);
    n_checks++;
    if (lat !== 0) begin
      n_fail++;
      $display("FAIL conf_prehit: latency %0d expected 0", lat);
    end
    do_load(alias_addr, 1'b0, d, lat);
    n_checks++;
    if ({lat == MISS_LAT, d} !== {1'b1, 32'h10101010}) begin
      n_fail++;
      $display("FAIL conf_alias: lat=%0d rdata=%h expected lat %0d rdata 10101010", lat, d, MISS_LAT);
    end
    n_checks++;
    if ((mem_seq.size() > 0 ? mem_seq[0] : 32'hxxxxxxxx) !== alias_addr) begin
      n_fail++;
      $display("FAIL conf_alias_addr: first read %h expected %h",
               (mem_seq.size() > 0 ? mem_seq[0] : 32'hxxxxxxxx), alias_addr);
    end
    do_load(32'h10, 1'b0, d, lat);
    n_checks++;
    if (lat !== MISS_LAT) begin
      n_fail++;
      $display("FAIL conf_evicted: latency %0d expected %0d", lat, MISS_LAT);
    end
    do_load(32'h14, 1'b0, d, lat);
    n_checks++;
    if ({lat == 0, d} !== {1'b1, 32'h14AB1414}) begin
      n_fail++;
      $display("FAIL conf_refill_data: lat=%0d rdata=%h expected lat 0 rdata 14AB1414", lat, d);
    end
  endtask

  task automatic test_reset_in_fill();
    logic [31:0] d;
    int          lat;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h30;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    #1;
    n_checks++;
    if ({ready, mem_master_enable, mem_write_enable, mem_byte_enable} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rfill_idle: {ready,mme,mwe,mbe}=%b expected 0000",
               {ready, mem_master_enable, mem_write_enable, mem_byte_enable});
    end
    do_load(32'h10, 1'b0, d, lat);
    n_checks++;
    if ({lat == MISS_LAT, d} !== {1'b1, 32'h10101010}) begin
      n_fail++;
      $display("FAIL rfill_reload10: lat=%0d rdata=%h expected lat %0d rdata 10101010", lat, d, MISS_LAT);
    end
    do_load(32'h30, 1'b0, d, lat);
    n_checks++;
    if ({lat == MISS_LAT, d} !== {1'b1, 32'h30303030}) begin
      n_fail++;
      $display("FAIL rfill_partial: lat=%0d rdata=%h expected lat %0d rdata 30303030", lat, d, MISS_LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int          lat;
    do_load(32'h18, 1'b0, d, lat);
    n_checks++;
    if ({lat == 0, d} !== {1'b1, 32'h18181818}) begin
      n_fail++;
      $display("FAIL b2b_hit: lat=%0d rdata=%h expected lat 0 rdata 18181818", lat, d);
    end
    do_store(32'h18, 1'b0, 32'hCAFEF00D);
    do_load(32'h18, 1'b0, d, lat);
    n_checks++;
    if ({lat == 0, d} !== {1'b1, 32'hCAFEF00D}) begin
      n_fail++;
      $display("FAIL b2b_word_store: lat=%0d rdata=%h expected lat 0 rdata CAFEF00D", lat, d);
    end
    do_store(32'h1B, 1'b1, 32'h00000055);
    do_load(32'h18, 1'b0, d, lat);
    n_checks++;
    if ({lat == 0, d} !== {1'b1, 32'hCAFEF055}) begin
      n_fail++;
      $display("FAIL b2b_byte_store: lat=%0d rdata=%h expected lat 0 rdata CAFEF055", lat, d);
    end
    do_load(32'h1B, 1'b1, d, lat);
    n_checks++;
    if (d !== 32'h00000055) begin
      n_fail++;
      $display("FAIL b2b_lane3: got %h expected 00000055", d);
    end
    n_checks++;
    if (mem_word(32'h18) !== 32'hCAFEF055) begin
      n_fail++;
      $display("FAIL b2b_memory: got %h expected CAFEF055", mem_word(32'h18));
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_cold_load();
    test_hit();
    test_byte_store();
    test_store_miss();
    test_conflict();
    test_reset_in_fill();
    test_back_to_back();
    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
